// File: rtl/psram_arb_rr.sv
// Round-robin arbiter for NCH client ports in front of the PSRAM controller.
// Issues one command per TCMD-cycle slot and steers read beats to the port that issued the read.
module psram_arb_rr #(
    parameter int NCH   = 4,
    parameter int AW    = 21,
    parameter int DW    = 64,
    parameter int MW    = 8,
    parameter int TCMD  = 19,
    parameter int BEATS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [AW-1:0]     o_psram_addr,
    output logic              o_psram_cmd,
    output logic              o_psram_cmd_en,
    output logic [DW-1:0]     o_psram_wr_data,
    output logic [MW-1:0]     o_psram_data_mask,
    input  logic [DW-1:0]     i_psram_rd_data,
    input  logic              i_psram_rd_data_valid,
    input  logic              i_psram_init_calib,
    input  logic [NCH-1:0]    i_req,
    input  logic [NCH-1:0]    i_we,
    input  logic [NCH*AW-1:0] i_addr,
    input  logic [NCH*DW-1:0] i_wdata,
    input  logic [NCH*MW-1:0] i_wmask,
    output logic [NCH-1:0]    o_gnt,
    output logic [DW-1:0]     o_rd_data,
    output logic [NCH-1:0]    o_rd_valid,
    output logic              o_rd_orphan
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TCMD) + 1;
    localparam int BW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TCMD - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [PW-1:0] PTR_INIT  = PW'(NCH - 1);

    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic           cmd_en_q, cmd_en_d;
    logic           cmd_q, cmd_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           rd_busy_q, rd_busy_d;
    logic [PW-1:0]  rd_owner_q, rd_owner_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           orphan_q, orphan_d;

    logic           free;
    logic           win_found;
    logic [PW-1:0]  win_idx;
    logic           grant;

    // Search starts just after the last winner so every port gets a turn.
    always_comb begin
        int tmp;
        logic [PW-1:0] idx;
        tmp       = 0;
        idx       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            tmp = int'(ptr_q) + i;
            if (tmp >= NCH) tmp = tmp - NCH;
            idx = PW'(tmp);
            if (!win_found && i_req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        free  = i_psram_init_calib && (cnt_q == '0);
        grant = free && win_found;
    end

    always_comb begin
        gnt_d      = '0;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        cmd_en_d   = |gnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        rd_busy_d  = rd_busy_q;
        rd_owner_d = rd_owner_q;
        beat_cnt_d = beat_cnt_q;
        orphan_d   = orphan_q | (i_psram_rd_data_valid & ~rd_busy_q);

        if (grant) begin
            gnt_d[win_idx] = 1'b1;
            ptr_d          = win_idx;
            owner_d        = win_idx;
            cnt_d          = CW'(1);
        end else if (cnt_q != '0) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end

        // Owner's address and direction are captured while the grant pulse is high.
        if (|gnt_q) begin
            cmd_d  = i_we[owner_q];
            addr_d = i_addr[int'(owner_q)*AW +: AW];
        end

        if (i_psram_rd_data_valid && rd_busy_q) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
            if (beat_cnt_q == BEAT_LAST) rd_busy_d = 1'b0;
        end

        if (grant && !i_we[win_idx]) begin
            rd_busy_d  = 1'b1;
            rd_owner_d = win_idx;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= PTR_INIT;
            owner_q    <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            cmd_en_q   <= 1'b0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            rd_busy_q  <= 1'b0;
            rd_owner_q <= '0;
            beat_cnt_q <= '0;
            orphan_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            cmd_en_q   <= cmd_en_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            rd_busy_q  <= rd_busy_d;
            rd_owner_q <= rd_owner_d;
            beat_cnt_q <= beat_cnt_d;
            orphan_q   <= orphan_d;
        end
    end

    always_comb begin
        o_rd_valid = '0;
        if (i_psram_rd_data_valid && rd_busy_q) o_rd_valid[rd_owner_q] = 1'b1;
    end

    assign o_psram_addr      = addr_q;
    assign o_psram_cmd       = cmd_q;
    assign o_psram_cmd_en    = cmd_en_q;
    assign o_psram_wr_data   = i_wdata[int'(owner_q)*DW +: DW];
    assign o_psram_data_mask = i_wmask[int'(owner_q)*MW +: MW];
    assign o_gnt             = gnt_q;
    assign o_rd_data         = i_psram_rd_data;
    assign o_rd_orphan       = orphan_q;

endmodule
